truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the cycles each vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock for the block; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a sweep; honoured only in IDLE.
REQ-005 mode4  input  1  0 = 3-variable sweep (8 vectors), 1 = 4-variable sweep (16 vectors); sampled with accepted start.
REQ-006 abort  input  1  terminates a sweep in progress.
REQ-007 a, b, c, d  output  1 each  registered input vector driven to SOP and POS implementations under test.
REQ-008 sop_in, pos_in  input  1 each  outputs of the SOP and POS implementations.
REQ-009 busy  output  1  high in DRIVE and SAMPLE.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 sop_table, pos_table  output  16 each  captured truth tables; bit i = response to vector index i.
REQ-012 mismatch_count  output  5  number of indices where sop_in != pos_in.
REQ-013 first_mismatch  output  4  lowest mismatching index; valid when mismatch_flag = 1.
REQ-014 mismatch_flag  output  1  1 if mismatch_count != 0.

Function
REQ-015 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE: start=1 -> DRIVE; latch mode4; index=0; clear tables, mismatch_count, first_mismatch, mismatch_flag.
REQ-017 Vector mapping: 4-var {a,b,c,d}=index[3:0], a is MSB; 3-var {a,b,c}=index[2:0], d=0.
REQ-018 DRIVE: vector held exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-019 SAMPLE (one cycle): write sop_in/pos_in to table bit index; on inequality increment mismatch_count, and if first mismatch record index and set mismatch_flag.
REQ-020 SAMPLE: index < N-1 -> index+1, DRIVE; index = N-1 -> DONE. N = 8 or 16.
REQ-021 DONE: done=1 for one cycle, then IDLE; results hold until next accepted start.
REQ-022 Latency: start accepted at edge k -> done high in cycle after edge k + N*(SETTLE_CYCLES+1).
REQ-023 start while busy or in DONE is ignored; no restart and no result change.
REQ-024 abort in DRIVE or SAMPLE -> IDLE next edge, no done pulse, partial results retained; abort has priority over the SAMPLE write in the same cycle.
REQ-025 abort in IDLE or DONE has no effect.
REQ-026 Index counter never exceeds N-1; unused table bits (15:8 in 3-var mode) remain 0.
REQ-027 mismatch_count saturates naturally at 16; no wrap.

Reset
REQ-028 rst=1 immediately forces IDLE, index=0, a/b/c/d=0, busy=0, done=0, tables=0, mismatch_count=0, first_mismatch=0, mismatch_flag=0, including mid-sweep.
REQ-029 After rst deasserts, no sweep starts without a new start.

Structure
REQ-030 Shared package holds the state enum and constants NVEC3=8, NVEC4=16.
REQ-031 One sub-module, tt_vec_counter: index and settle counters with clear/enable/terminal-count outputs.

Verification
REQ-032 mode4=0, 3-var SOP !A!B+!BC+B!C vs POS (!A+B+C)(!B+!C) -> sop_table=pos_table=0x0067, mismatch_count=0, mismatch_flag=0, done at cycle 17 with SETTLE_CYCLES=1.
REQ-033 mode4=1, sop_in=1, pos_in=0 -> mismatch_count=16, first_mismatch=0, sop_table=0xFFFF, pos_table=0x0000, done at cycle 33.
REQ-034 mode4=1, sop_in=a, pos_in=0 -> mismatch_count=8, first_mismatch=8, sop_table=0xFF00.
REQ-035 abort at index 5 in 4-var sweep -> IDLE next edge, no done, mismatch_count reflects indices 0..4 only; start during sweep ignored.
REQ-036 rst asserted mid-sweep (index 10) -> all outputs 0 asynchronously; subsequent start runs full sweep correctly.

Source files
------------

// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
// Holds the sweep FSM encoding and the vector-index mapping helper.
package truth_table_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   localparam int NVEC3 = 8;
   localparam int NVEC4 = 16;

   localparam logic [3:0] LAST3 = 4'(NVEC3 - 1);
   localparam logic [3:0] LAST4 = 4'(NVEC4 - 1);

   // Returns {a,b,c,d}; in 3-variable mode d is tied low.
   function automatic logic [3:0] vec_map(input logic [3:0] idx,
                                          input logic       m4);
      return m4 ? idx : {idx[2:0], 1'b0};
   endfunction

endpackage

// File: rtl/truth_table_sequencer_vec_counter.sv
// Vector index counter and settle-time counter for the sequencer.
// Both counters saturate at their terminal count.
module tt_vec_counter
   import truth_table_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       idx_clr,
   input  logic       idx_en,
   input  logic [3:0] idx_last,
   output logic [3:0] idx,
   output logic       idx_tc,
   input  logic       settle_clr,
   input  logic       settle_en,
   output logic       settle_tc
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [3:0] idx_q, idx_d;
   logic [3:0] settle_q, settle_d;

   assign idx       = idx_q;
   assign idx_tc    = (idx_q == idx_last);
   assign settle_tc = (settle_q == SETTLE_LAST);

   always_comb begin
      idx_d = idx_q;
      if (idx_clr) begin
         idx_d = 4'd0;
      end else if (idx_en && !idx_tc) begin
         idx_d = idx_q + 4'd1;
      end
   end

   always_comb begin
      settle_d = settle_q;
      if (settle_clr) begin
         settle_d = 4'd0;
      end else if (settle_en && !settle_tc) begin
         settle_d = settle_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= 4'd0;
         settle_q <= 4'd0;
      end else begin
         idx_q    <= idx_d;
         settle_q <= settle_d;
      end
   end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps 3- or 4-variable input vectors into SOP/POS implementations
// and captures both truth tables plus mismatch statistics.
module truth_table_sequencer
   import truth_table_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode4,
   input  logic        abort,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        sop_in,
   input  logic        pos_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] sop_table,
   output logic [15:0] pos_table,
   output logic [4:0]  mismatch_count,
   output logic [3:0]  first_mismatch,
   output logic        mismatch_flag
);

   state_e      state_q, state_d;
   logic        mode4_q, mode4_d;
   logic [3:0]  vec_q, vec_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] sop_q, sop_d;
   logic [15:0] pos_q, pos_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  first_q, first_d;
   logic        flag_q, flag_d;

   logic [3:0]  idx;
   logic        idx_tc;
   logic        settle_tc;
   logic        start_acc;

   assign start_acc = (state_q == ST_IDLE) && start;

   tt_vec_counter #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .idx_clr    (start_acc),
      .idx_en     ((state_q == ST_SAMPLE) && !abort),
      .idx_last   (mode4_q ? LAST4 : LAST3),
      .idx        (idx),
      .idx_tc     (idx_tc),
      .settle_clr (state_q != ST_DRIVE),
      .settle_en  ((state_q == ST_DRIVE) && !abort),
      .settle_tc  (settle_tc)
   );

   always_comb begin
      state_d = state_q;
      mode4_d = mode4_q;
      vec_d   = vec_q;
      done_d  = 1'b0;
      sop_d   = sop_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      flag_d  = flag_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DRIVE;
               mode4_d = mode4;
               vec_d   = 4'd0;
               sop_d   = 16'd0;
               pos_d   = 16'd0;
               cnt_d   = 5'd0;
               first_d = 4'd0;
               flag_d  = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (settle_tc) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            // Abort wins: the in-flight sample is dropped.
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               sop_d[idx] = sop_in;
               pos_d[idx] = pos_in;
               if (sop_in != pos_in) begin
                  cnt_d = cnt_q + 5'd1;
                  if (!flag_q) begin
                     first_d = idx;
                     flag_d  = 1'b1;
                  end
               end
               if (idx_tc) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_DRIVE;
                  vec_d   = vec_map(idx + 4'd1, mode4_q);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode4_q <= 1'b0;
         vec_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sop_q   <= 16'd0;
         pos_q   <= 16'd0;
         cnt_q   <= 5'd0;
         first_q <= 4'd0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode4_q <= mode4_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sop_q   <= sop_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         flag_q  <= flag_d;
      end
   end

   assign a              = vec_q[3];
   assign b              = vec_q[2];
   assign c              = vec_q[1];
   assign d              = vec_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign sop_table      = sop_q;
   assign pos_table      = pos_q;
   assign mismatch_count = cnt_q;
   assign first_mismatch = first_q;
   assign mismatch_flag  = flag_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed-vector bench for truth_table_sequencer.
// Models the SOP/POS implementations combinationally from a,b,c,d.
module tb_truth_table_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, mode4, abort;
   logic        a, b, c, d;
   logic        sop_in, pos_in;
   logic        busy, done;
   logic [15:0] sop_table, pos_table;
   logic [4:0]  mismatch_count;
   logic [3:0]  first_mismatch;
   logic        mismatch_flag;
   logic [2:0]  fsel;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   truth_table_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode4          (mode4),
      .abort          (abort),
      .a              (a),
      .b              (b),
      .c              (c),
      .d              (d),
      .sop_in         (sop_in),
      .pos_in         (pos_in),
      .busy           (busy),
      .done           (done),
      .sop_table      (sop_table),
      .pos_table      (pos_table),
      .mismatch_count (mismatch_count),
      .first_mismatch (first_mismatch),
      .mismatch_flag  (mismatch_flag)
   );

   always_comb begin
      sop_in = 1'b0;
      pos_in = 1'b0;
      case (fsel)
         3'd0: begin
            sop_in = (!a && !b) || (!b && c) || (b && !c);
            pos_in = (!a || b || c) && (!b || !c);
         end
         3'd1: sop_in = 1'b1;
         3'd2: sop_in = a;
         3'd3: sop_in = b ^ d;
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic kick(input logic m4);
      @(negedge clk);
      mode4 = m4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic sweep(input logic m4, input int lat, input string tag);
      int  n;
      bit  seen;
      kick(m4);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      n    = 0;
      seen = 0;
      while (!seen && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (done) seen = 1;
      end
      chk({tag, "_lat"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(lat));
      start = 1'b1;
      mode4 = ~m4;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_norestart"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_vec(input logic [3:0] v, input string tag);
      int n;
      bit hit;
      n   = 0;
      hit = 0;
      while (!hit && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if ({a, b, c, d} == v) hit = 1;
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      int nd;
      rst   = 1'b1;
      start = 1'b0;
      mode4 = 1'b0;
      abort = 1'b0;
      fsel  = 3'd0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_vec", 32'({a, b, c, d}), 32'd0);
      chk("rst_tab", 32'({sop_table, pos_table}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_nostart", 32'(busy), 32'd0);

      // 3-var SOP vs POS, equivalent
      fsel = 3'd0;
      sweep(1'b0, 16, "eq3");
      chk("eq3_sop", 32'(sop_table), 32'h0067);
      chk("eq3_pos", 32'(pos_table), 32'h0067);
      chk("eq3_cnt", 32'(mismatch_count), 32'd0);
      chk("eq3_flag", 32'(mismatch_flag), 32'd0);

      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("idle_abort", 32'(sop_table), 32'h0067);

      // 4-var, all mismatch
      fsel = 3'd1;
      sweep(1'b1, 32, "all4");
      chk("all4_cnt", 32'(mismatch_count), 32'd16);
      chk("all4_first", 32'(first_mismatch), 32'd0);
      chk("all4_sop", 32'(sop_table), 32'hFFFF);
      chk("all4_pos", 32'(pos_table), 32'h0000);
      chk("all4_flag", 32'(mismatch_flag), 32'd1);

      // 3-var, upper table bits must stay clear
      sweep(1'b0, 16, "all3");
      chk("all3_cnt", 32'(mismatch_count), 32'd8);
      chk("all3_sop", 32'(sop_table), 32'h00FF);

      // sop = a
      fsel = 3'd2;
      sweep(1'b1, 32, "a4");
      chk("a4_cnt", 32'(mismatch_count), 32'd8);
      chk("a4_first", 32'(first_mismatch), 32'd8);
      chk("a4_sop", 32'(sop_table), 32'hFF00);

      // sop = b^d
      fsel = 3'd3;
      sweep(1'b1, 32, "bd4");
      chk("bd4_cnt", 32'(mismatch_count), 32'd8);
      chk("bd4_first", 32'(first_mismatch), 32'd1);
      chk("bd4_sop", 32'(sop_table), 32'h5A5A);

      // abort in DRIVE at index 5, with ignored start mid-sweep
      fsel = 3'd1;
      kick(1'b1);
      wait_vec(4'd2, "ab_reach2");
      start = 1'b1;
      mode4 = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_vec(4'd5, "ab_reach5");
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_cnt", 32'(mismatch_count), 32'd5);
      chk("ab_sop", 32'(sop_table), 32'h001F);
      chk("ab_first", 32'(first_mismatch), 32'd0);
      nd = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      chk("ab_nodone", 32'(nd), 32'd0);

      // abort in SAMPLE of index 2 drops that sample
      kick(1'b1);
      wait_vec(4'd2, "abs_reach2");
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abs_cnt", 32'(mismatch_count), 32'd2);
      chk("abs_sop", 32'(sop_table), 32'h0003);

      // async reset mid-sweep
      kick(1'b1);
      wait_vec(4'd10, "rs_reach10");
      #2;
      rst = 1'b1;
      #1;
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_vec", 32'({a, b, c, d}), 32'd0);
      chk("rs_cnt", 32'(mismatch_count), 32'd0);
      chk("rs_tab", 32'({sop_table, pos_table}), 32'd0);
      chk("rs_flag", 32'({mismatch_flag, first_mismatch}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rs_idle", 32'(busy), 32'd0);
      fsel = 3'd2;
      sweep(1'b1, 32, "rs_a4");
      chk("rs_a4_cnt", 32'(mismatch_count), 32'd8);
      chk("rs_a4_first", 32'(first_mismatch), 32'd8);
      chk("rs_a4_sop", 32'(sop_table), 32'hFF00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
